// File: rtl/irq_pending_sequencer.sv
// Rising-edge request capture into a sticky pending register, lowest-index-first
// grant over valid/ready. Optional overrun flags are built when IRQ_OVERRUN_EN is defined.
module irq_pending_sequencer #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [NUM_REQ-1:0] pending,
`ifdef IRQ_OVERRUN_EN
  input  logic               overrun_clr,
  output logic [NUM_REQ-1:0] overrun,
`endif
  output logic               busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [NUM_REQ-1:0] req_q_r;
  logic [NUM_REQ-1:0] edge_s;
  logic [NUM_REQ-1:0] clr_s;
  logic [NUM_REQ-1:0] pending_s;
  logic [IDX_W-1:0]   idx_s;
  logic               accept_s;
  logic               valid_s;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign edge_s   = req & ~req_q_r;
  assign accept_s = (state_r == OFFER) & out_ready;
  assign clr_s    = accept_s ? (NUM_REQ'(1'b1) << out_idx) : {NUM_REQ{1'b0}};
  assign busy     = (pending != {NUM_REQ{1'b0}}) | out_valid;

  // A set in the same cycle as a clear keeps the bit pending.
  always_comb begin
    pending_s = {NUM_REQ{1'b0}};
    if (flush) begin
      pending_s = {NUM_REQ{1'b0}};
    end else begin
      pending_s = (pending & ~clr_s) | edge_s;
    end
  end

  always_comb begin
    state_s = state_r;
    idx_s   = out_idx;
    case (state_r)
      IDLE: begin
        if (!flush && (pending != {NUM_REQ{1'b0}})) begin
          state_s = OFFER;
          idx_s   = lowest_set(pending);
        end else begin
          state_s = IDLE;
        end
      end
      OFFER: begin
        if (flush || out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = OFFER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    valid_s = (state_s == OFFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q_r   <= {NUM_REQ{1'b0}};
      pending   <= {NUM_REQ{1'b0}};
      state_r   <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= {IDX_W{1'b0}};
    end else begin
      req_q_r   <= req;
      pending   <= pending_s;
      state_r   <= state_s;
      out_valid <= valid_s;
      out_idx   <= idx_s;
    end
  end

`ifdef IRQ_OVERRUN_EN
  logic [NUM_REQ-1:0] ovr_set_s;
  logic [NUM_REQ-1:0] overrun_s;

  // A repeat edge counts only if the bit survives this cycle; flush clears it.
  always_comb begin
    ovr_set_s = {NUM_REQ{1'b0}};
    overrun_s = overrun;
    if (flush) begin
      ovr_set_s = {NUM_REQ{1'b0}};
    end else begin
      ovr_set_s = edge_s & pending & ~clr_s;
    end
    if (overrun_clr) begin
      overrun_s = ovr_set_s;
    end else begin
      overrun_s = overrun | ovr_set_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= {NUM_REQ{1'b0}};
    end else begin
      overrun <= overrun_s;
    end
  end
`endif

endmodule

// File: tb/tb_irq_pending_sequencer.sv
// Directed bench for irq_pending_sequencer: per-cycle comparison against a
// behavioural model plus literal expectations on grant order and key states.
module tb_irq_pending_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       busy;
`ifdef IRQ_OVERRUN_EN
  logic       overrun_clr;
  logic [7:0] overrun;
`endif

  int n_vec = 0;
  int n_err = 0;
  int grants[$];

  always #5 clk = ~clk;

  irq_pending_sequencer #(.NUM_REQ(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .pending    (pending),
`ifdef IRQ_OVERRUN_EN
    .overrun_clr(overrun_clr),
    .overrun    (overrun),
`endif
    .busy       (busy)
  );

  // Behavioural model: set of pending lines, an open offer, and the offered index.
  logic [7:0] m_prev;
  logic [7:0] m_pending;
  logic [7:0] m_edges;
  logic       m_offer;
  logic [2:0] m_idx;
  logic       m_accept;

  function automatic logic [2:0] first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  assign m_edges  = req & ~m_prev;
  assign m_accept = m_offer & out_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev    <= 8'h00;
      m_pending <= 8'h00;
      m_offer   <= 1'b0;
      m_idx     <= 3'd0;
    end else begin
      m_prev <= req;
      if (flush) begin
        m_pending <= 8'h00;
        m_offer   <= 1'b0;
      end else if (m_accept) begin
        m_pending <= (m_pending & ~(8'd1 << m_idx)) | m_edges;
        m_offer   <= 1'b0;
      end else if (m_offer) begin
        m_pending <= m_pending | m_edges;
      end else begin
        m_pending <= m_pending | m_edges;
        if (m_pending != 8'h00) begin
          m_offer <= 1'b1;
          m_idx   <= first_set(m_pending);
        end
      end
    end
  end

`ifdef IRQ_OVERRUN_EN
  logic [7:0] m_ovr;
  logic [7:0] m_reps;
  assign m_reps = flush ? 8'h00
                : (m_edges & m_pending & ~(m_accept ? (8'd1 << m_idx) : 8'h00));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_ovr <= 8'h00;
    else if (overrun_clr) m_ovr <= m_reps;
    else m_ovr <= m_ovr | m_reps;
  end
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_valid", out_valid, m_offer);
      check("model_idx", out_idx, m_idx);
      check("model_pending", pending, m_pending);
      check("model_busy", busy, (m_pending != 8'h00) || m_offer);
`ifdef IRQ_OVERRUN_EN
      check("model_overrun", overrun, m_ovr);
`endif
      if (out_valid && out_ready) grants.push_back(int'(out_idx));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_grants(input string name, input int exp[4]);
    check({name, "_count"}, grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check({name, "_order"}, grants[i], exp[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_a5[4];
    int exp_0f[4];
    exp_a5 = '{0, 2, 5, 7};
    exp_0f = '{0, 1, 2, 3};
    rst_n     = 1'b0;
    req       = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
`ifdef IRQ_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    cyc(3);
    check("reset_valid", out_valid, 1'b0);
    check("reset_idx", out_idx, 3'd0);
    check("reset_pending", pending, 8'h00);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    cyc(1);

    // Single request on line 4
    req = 8'h10;
    cyc(1);
    check("single_pending", pending, 8'h10);
    check("single_not_yet", out_valid, 1'b0);
    req = 8'h00;
    cyc(1);
    check("single_valid", out_valid, 1'b1);
    check("single_idx", out_idx, 3'd4);
    out_ready = 1'b1;
    cyc(1);
    check("single_cleared", pending, 8'h00);
    check("single_busy", busy, 1'b0);
    out_ready = 1'b0;
    cyc(1);

    // Priority order
    grants.delete();
    req = 8'hA5;
    out_ready = 1'b1;
    cyc(1);
    req = 8'h00;
    cyc(12);
    out_ready = 1'b0;
    check_grants("a5", exp_a5);
    check("a5_idle", busy, 1'b0);

    // Backpressure, no pre-emption
    req = 8'h80;
    cyc(1);
    req = 8'h00;
    cyc(6);
    req = 8'h02;
    cyc(1);
    req = 8'h00;
    cyc(2);
    check("bp_valid", out_valid, 1'b1);
    check("bp_idx_held", out_idx, 3'd7);
    check("bp_pending", pending, 8'h82);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    check("bp_gap", out_valid, 1'b0);
    cyc(1);
    check("bp_next_idx", out_idx, 3'd1);
    check("bp_next_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    check("bp_drained", pending, 8'h00);

    // Simultaneous set and clear on line 3
    req = 8'h08;
    cyc(1);
    req = 8'h00;
    cyc(1);
    check("sc_offer_idx", out_idx, 3'd3);
    req = 8'h08;
    out_ready = 1'b1;
    cyc(1);
    req = 8'h00;
    out_ready = 1'b0;
    check("sc_still_pending", pending, 8'h08);
    cyc(1);
    check("sc_reoffer_valid", out_valid, 1'b1);
    check("sc_reoffer_idx", out_idx, 3'd3);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    check("sc_drained", pending, 8'h00);

    // Held level: exactly four grants
    grants.delete();
    req = 8'h0F;
    out_ready = 1'b1;
    cyc(12);
    check_grants("held", exp_0f);
    req = 8'h00;
    out_ready = 1'b0;
    cyc(2);
    check("held_idle", busy, 1'b0);

    // Flush mid-sequence with level still held
    req = 8'h0F;
    out_ready = 1'b1;
    cyc(4);
    check("fl_pre_valid", out_valid, 1'b1);
    check("fl_pre_idx", out_idx, 3'd1);
    flush = 1'b1;
    out_ready = 1'b0;
    cyc(1);
    flush = 1'b0;
    check("fl_valid", out_valid, 1'b0);
    check("fl_pending", pending, 8'h00);
    cyc(6);
    check("fl_quiet_valid", out_valid, 1'b0);
    check("fl_quiet_busy", busy, 1'b0);
    req = 8'h00;
    cyc(2);

    // Async reset while offering
    req = 8'h01;
    cyc(1);
    req = 8'h00;
    cyc(1);
    check("ar_pre_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_pending", pending, 8'h00);
    check("ar_busy", busy, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

`ifdef IRQ_OVERRUN_EN
    req = 8'h04;
    cyc(1);
    req = 8'h00;
    cyc(1);
    req = 8'h04;
    cyc(1);
    req = 8'h00;
    cyc(1);
    check("ovr_set", overrun, 8'h04);
    cyc(2);
    check("ovr_sticky", overrun, 8'h04);
    overrun_clr = 1'b1;
    cyc(1);
    overrun_clr = 1'b0;
    check("ovr_cleared", overrun, 8'h00);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(2);
    check("ovr_drained", busy, 1'b0);
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_pending_sequencer.md
Name: irq_pending_sequencer

Overview:
Request-capture and sequencing stage feeding the 8-to-3 priority encode path. Captures rising edges on 8 request lines into a sticky pending register and selects the lowest-index pending line (index 0 = highest priority). Offers that index downstream over a valid/ready handshake, and clears the line once the index is accepted. Converts asynchronous-looking level requests into an ordered stream of 3-bit indices.

Parameters:
NUM_REQ, 8, number of request lines; only 8 is supported.
IDX_W, 3, index width; must equal clog2(NUM_REQ).

Ports:
clk  input  1  single clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  request lines, level, synchronous to clk
flush  input  1  synchronous clear of all pending bits and any open offer
out_valid  output  1  out_idx is valid
out_ready  input  1  downstream accepts out_idx when high together with out_valid
out_idx  output  IDX_W  index of the granted line
pending  output  NUM_REQ  current sticky pending register
busy  output  1  high when pending is nonzero or out_valid is high

Behaviour:
- Reset (rst_n low, asynchronous, any cycle) clears the following: req_q=0, pending=0, out_valid=0, out_idx=0, state=IDLE. An in-flight offer is dropped, with no partial clear.
- Edge detect: req_q is req delayed one cycle. edge = req & ~req_q. A line held high sets pending once only; it must fall and rise again to re-request.
- Pending update each cycle: pending_next = (pending & ~clr) | edge. clr is the one-hot of out_idx on an accepted handshake, otherwise 0. If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays pending.
- State machine, two states:
  - IDLE: out_valid=0. If pending != 0, load out_idx = lowest set index of the registered pending value and go to OFFER. Edges arriving in the same cycle are not considered until the next cycle.
  - OFFER: out_valid=1, and out_idx is held stable. On out_ready=1, clear pending[out_idx] and go to IDLE. On out_ready=0, stay in OFFER. A higher-priority edge arriving during OFFER does not change out_idx: there is no pre-emption once the index is offered.
- Latency: req rises before edge k → pending bit set at edge k → out_valid high after edge k+1, with out_idx valid.
- Throughput: at most one grant every 2 cycles, because the IDLE cycle after each acceptance is mandatory.
- flush=1: pending=0 and state=IDLE, with out_valid low from the next cycle. req_q still updates, so lines held high during flush do not re-pend. flush takes priority over the handshake and over edges in the same cycle.
- All-zero pending: the block stays in IDLE, out_valid=0, out_idx holds its last value.
- busy = (pending != 0) | out_valid, combinational from registers.
- All outputs are registered except busy.

Optional Feature:
Macro: IRQ_OVERRUN_EN.
- With the macro defined: adds output overrun [NUM_REQ] and input overrun_clr [1]. overrun[i] is a sticky flag, set when an edge on line i arrives while pending[i] is already 1 and is not being cleared in that cycle. The flag is cleared by overrun_clr=1 or by reset. If a set and overrun_clr occur together, the set wins.
- Without the macro: neither port exists, no overrun logic is built, and the repeat edge is silently absorbed.

Test Plan:
- Reset/single request: hold rst_n=0 → all outputs 0. Release, pulse req=8'h10 for 1 cycle → out_valid=1 two cycles later with out_idx=3'd4. With out_ready=1 → pending=0, busy=0 next cycle.
- Priority order: req=8'hA5 in one cycle, out_ready=1 constantly → out_idx sequence 0,2,5,7, one grant per 2 cycles, then idle.
- Backpressure/no pre-emption: pending=8'h80 offered (idx 7) with out_ready=0 for 5 cycles, then edge on req[1] → out_idx stays 7 until accepted, then offers 1.
- Simultaneous set/clear: edge on req[3] in the same cycle idx 3 is accepted → pending[3] remains 1 and idx 3 is re-offered.
- Held level and flush: req=8'h0F held high → exactly 4 grants, no repeats. Repeat with flush asserted mid-sequence → out_valid low next cycle, pending=0, no further grants while req is held.
- Async reset mid-offer: rst_n low while out_valid=1 → out_valid drops immediately without waiting for clk. IRQ_OVERRUN_EN build: two edges on req[2] before acceptance → overrun=8'h04 until overrun_clr.
